// File: rtl/vga_pattern_gen.sv
// Two-stage VGA test-pattern pixel pipeline: solid, colour bars, checker and scrolling gradient.
// Optional monitor-alignment border enabled by defining VGA_PATTERN_BORDER_EN.
module vga_pattern_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int H_LAST     = 799,
  parameter int V_LAST     = 524,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        visible_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [9:0]  column_i,
  input  logic [9:0]  row_i,
  input  logic [1:0]  mode_i,
  input  logic [11:0] color_i,
  output logic        visible_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [3:0]  red_o,
  output logic [3:0]  green_o,
  output logic [3:0]  blue_o,
  output logic [7:0]  frame_o
);

  localparam int BAR_W = H_VISIBLE / 8;

  logic [7:0]  r_frame;
  logic [1:0]  r_mode;

  logic        r_vis1;
  logic        r_hs1;
  logic        r_vs1;
  logic [1:0]  r_mode1;
  logic [2:0]  r_bar1;
  logic        r_chk1;
  logic [7:0]  r_scroll1;
  logic [3:0]  r_rowb1;
  logic [11:0] r_color1;

  logic        r_vis2;
  logic        r_hs2;
  logic        r_vs2;
  logic [11:0] r_rgb2;

  logic        w_eof;
  logic [2:0]  w_bar;
  logic        w_chk;
  logic [7:0]  w_scroll;
  logic [11:0] w_rgb;

  assign w_eof    = (row_i == 10'(V_LAST)) && (column_i == 10'(H_LAST));
  assign w_chk    = column_i[CHECK_LOG2] ^ row_i[CHECK_LOG2];
  assign w_scroll = column_i[7:0] + r_frame;

  // Bar index counts the bar boundaries already passed; saturates at 7 past the visible width.
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (column_i >= 10'(k * BAR_W)) w_bar = w_bar + 3'd1;
    end
  end

  // Mode is latched only at end of frame so a frame never mixes patterns.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_frame <= 8'd0;
      r_mode  <= 2'd0;
    end else if (w_eof) begin
      r_frame <= r_frame + 8'd1;
      r_mode  <= mode_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_vis1    <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_mode1   <= 2'd0;
      r_bar1    <= 3'd0;
      r_chk1    <= 1'b0;
      r_scroll1 <= 8'd0;
      r_rowb1   <= 4'd0;
      r_color1  <= 12'd0;
    end else begin
      r_vis1    <= visible_i;
      r_hs1     <= hsync_i;
      r_vs1     <= vsync_i;
      r_mode1   <= r_mode;
      r_bar1    <= w_bar;
      r_chk1    <= w_chk;
      r_scroll1 <= w_scroll;
      r_rowb1   <= row_i[8:5];
      r_color1  <= color_i;
    end
  end

`ifdef VGA_PATTERN_BORDER_EN
  logic w_border;
  logic r_border1;

  assign w_border = (column_i == 10'd0) || (column_i == 10'(H_VISIBLE - 1)) ||
                    (row_i == 10'd0) || (row_i == 10'(V_VISIBLE - 1));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_border1 <= 1'b0;
    else           r_border1 <= w_border;
  end
`endif

  // Bar order white..black maps to R = ~bar[1], G = ~bar[2], B = ~bar[0].
  always_comb begin
    w_rgb = 12'h000;
    if (r_vis1) begin
      case (r_mode1)
        2'd0: w_rgb = r_color1;
        2'd1: w_rgb = {{4{~r_bar1[1]}}, {4{~r_bar1[2]}}, {4{~r_bar1[0]}}};
        2'd2: w_rgb = {12{r_chk1}};
        default: w_rgb = {r_scroll1[7:4], ~r_scroll1[7:4], r_rowb1};
      endcase
`ifdef VGA_PATTERN_BORDER_EN
      if (r_border1) w_rgb = 12'hFFF;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_vis2 <= 1'b0;
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
      r_rgb2 <= 12'd0;
    end else begin
      r_vis2 <= r_vis1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_rgb2 <= w_rgb;
    end
  end

  assign visible_o = r_vis2;
  assign hsync_o   = r_hs2;
  assign vsync_o   = r_vs2;
  assign red_o     = r_rgb2[11:8];
  assign green_o   = r_rgb2[7:4];
  assign blue_o    = r_rgb2[3:0];
  assign frame_o   = r_frame;

endmodule
